// File: rtl/fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC register, fetch address error check
// and the IF/ID pipeline register, with stall, delay-slot redirect, exception and eret.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        bd_d,
    output logic        exc_d,
    output logic [4:0]  exccode_d
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic        fetch_bad;
    logic [31:0] pc_f_next;
    logic [31:0] instr_d_next;
    logic [31:0] pc_d_next;
    logic        bd_d_next;
    logic        exc_d_next;
    logic [4:0]  exccode_d_next;

    assign fetch_bad = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_LIMIT);

    always_comb begin
        pc_f_next      = pc_f;
        instr_d_next   = instr_d;
        pc_d_next      = pc_d;
        bd_d_next      = bd_d;
        exc_d_next     = exc_d;
        exccode_d_next = exccode_d;
        if (exc_req) begin
            pc_f_next      = HANDLER_PC;
            instr_d_next   = 32'h0;
            pc_d_next      = HANDLER_PC;
            bd_d_next      = 1'b0;
            exc_d_next     = 1'b0;
            exccode_d_next = 5'd0;
        end else if (eret) begin
            pc_f_next      = epc;
            instr_d_next   = 32'h0;
            pc_d_next      = epc;
            bd_d_next      = 1'b0;
            exc_d_next     = 1'b0;
            exccode_d_next = 5'd0;
        end else if (!stall) begin
            // Capture the current fetch; with a redirect it is the delay slot.
            pc_f_next      = redirect ? redirect_pc : pc_f + 32'd4;
            pc_d_next      = pc_f;
            bd_d_next      = redirect;
            instr_d_next   = fetch_bad ? 32'h0 : instr_in;
            exc_d_next     = fetch_bad;
            exccode_d_next = fetch_bad ? EXC_ADEL : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f      <= RESET_PC;
            instr_d   <= 32'h0;
            pc_d      <= RESET_PC;
            pc8_d     <= RESET_PC + 32'd8;
            bd_d      <= 1'b0;
            exc_d     <= 1'b0;
            exccode_d <= 5'd0;
        end else begin
            pc_f      <= pc_f_next;
            instr_d   <= instr_d_next;
            pc_d      <= pc_d_next;
            pc8_d     <= pc_d_next + 32'd8;
            bd_d      <= bd_d_next;
            exc_d     <= exc_d_next;
            exccode_d <= exccode_d_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a combinational instruction memory model and
// hand-computed expectations for reset, sequencing, redirect, stall, exception, eret, AdEL.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] instr_in;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        bd_d;
    logic        exc_d;
    logic [4:0]  exccode_d;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .instr_in    (instr_in),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc8_d       (pc8_d),
        .bd_d        (bd_d),
        .exc_d       (exc_d),
        .exccode_d   (exccode_d)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign instr_in = word_at(pc_f);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_pc_f, input logic [31:0] e_instr,
                              input logic [31:0] e_pc_d, input logic e_bd, input logic e_exc);
        check_eq({tag, ".pc_f"}, pc_f, e_pc_f);
        check_eq({tag, ".instr_d"}, instr_d, e_instr);
        check_eq({tag, ".pc_d"}, pc_d, e_pc_d);
        check_eq({tag, ".pc8_d"}, pc8_d, e_pc_d + 32'd8);
        check_eq({tag, ".bd_d"}, {31'd0, bd_d}, {31'd0, e_bd});
        check_eq({tag, ".exc_d"}, {31'd0, exc_d}, {31'd0, e_exc});
        check_eq({tag, ".exccode_d"}, {27'd0, exccode_d}, e_exc ? 32'd4 : 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        exc_req = 1'b0; eret = 1'b0; epc = 32'h0;

        // Asynchronous reset mid-cycle, before any clock edge
        #3 rst_n = 1'b0;
        #1 check_ifid("reset", 32'h3000, 32'h0, 32'h3000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(); step(); step();
        check_ifid("seq3", 32'h300C, word_at(32'h3008), 32'h3008, 1'b0, 1'b0);

        // Branch: current fetch becomes the delay slot
        redirect = 1'b1; redirect_pc = 32'h3100;
        step();
        check_ifid("branch", 32'h3100, word_at(32'h300C), 32'h300C, 1'b1, 1'b0);
        redirect = 1'b0;
        step();
        check_ifid("branch_tgt", 32'h3104, word_at(32'h3100), 32'h3100, 1'b0, 1'b0);

        // Stall holds everything even with redirect asserted
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3200;
        step(); step();
        check_ifid("stall_redir", 32'h3104, word_at(32'h3100), 32'h3100, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        check_ifid("redir_after_stall", 32'h3200, word_at(32'h3104), 32'h3104, 1'b1, 1'b0);
        redirect = 1'b0;

        // Exception overrides stall
        stall = 1'b1; exc_req = 1'b1;
        step();
        check_ifid("exc", 32'h4180, 32'h0, 32'h4180, 1'b0, 1'b0);
        stall = 1'b0; exc_req = 1'b0;
        step();
        check_ifid("handler", 32'h4184, word_at(32'h4180), 32'h4180, 1'b0, 1'b0);

        // eret: no delay slot
        eret = 1'b1; epc = 32'h3024;
        step();
        check_eq("eret.pc_f", pc_f, 32'h3024);
        check_eq("eret.instr_d", instr_d, 32'h0);
        check_eq("eret.bd_d", {31'd0, bd_d}, 32'd0);
        eret = 1'b0;
        step();
        check_ifid("eret_ret", 32'h3028, word_at(32'h3024), 32'h3024, 1'b0, 1'b0);

        // Misaligned redirect target -> AdEL on following capture, PC keeps incrementing
        redirect = 1'b1; redirect_pc = 32'h3002;
        step();
        check_ifid("mis_redir", 32'h3002, word_at(32'h3028), 32'h3028, 1'b1, 1'b0);
        redirect = 1'b0;
        step();
        check_ifid("mis_adel", 32'h3006, 32'h0, 32'h3002, 1'b0, 1'b1);

        // Out-of-range redirect target
        redirect = 1'b1; redirect_pc = 32'h7000;
        step();
        check_ifid("oor_redir", 32'h7000, 32'h0, 32'h3006, 1'b1, 1'b1);
        redirect = 1'b0;
        step();
        check_ifid("oor_adel", 32'h7004, 32'h0, 32'h7000, 1'b0, 1'b1);

        // Upper boundary is legal, lower boundary - 4 is not
        eret = 1'b1; epc = 32'h6FFC;
        step();
        eret = 1'b0;
        step();
        check_ifid("limit_ok", 32'h7000, word_at(32'h6FFC), 32'h6FFC, 1'b0, 1'b0);
        eret = 1'b1; epc = 32'h2FFC;
        step();
        eret = 1'b0;
        step();
        check_ifid("below_base", 32'h3000, 32'h0, 32'h2FFC, 1'b0, 1'b1);
        step();
        check_ifid("base_ok", 32'h3004, word_at(32'h3000), 32'h3000, 1'b0, 1'b0);

        // PC wraps mod 2^32
        eret = 1'b1; epc = 32'hFFFF_FFFC;
        step();
        eret = 1'b0;
        step();
        check_ifid("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1);

        // Asynchronous reset during operation
        #2 rst_n = 1'b0;
        #1 check_ifid("reset2", 32'h3000, 32'h0, 32'h3000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
